// File: rtl/display_source_sequencer.sv
// display_source_sequencer
// Round-robin scheduler that shares the 0-19 seven-segment display between
// four 5-bit processor sources. One enabled source is shown at a time; it is
// held for DWELL cycles (auto mode) or until a step button edge, then the
// next enabled source is selected. Values above 19 are clamped and flagged.
module display_source_sequencer #(
    parameter int DWELL = 50000000,
    parameter int CNT_W = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] src0,
    input  logic [4:0] src1,
    input  logic [4:0] src2,
    input  logic [4:0] src3,
    input  logic [3:0] src_en,
    input  logic       mode_auto,
    input  logic       step,
    input  logic       frz,
    output logic [4:0] disp_val,
    output logic [1:0] disp_sel,
    output logic       disp_blank,
    output logic       ovr
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Counter value on which the auto dwell expires.
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           state_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             step_q;
    logic [4:0]       val_q;
    logic             ovr_q;
    logic             blank_q;

    logic [4:0]       src_arr [4];
    logic [4:0]       cur_src;
    logic             step_edge;
    logic             dwell_done;
    logic             cur_off;
    logic             advance;
    logic [1:0]       sel_first_d;
    logic [1:0]       sel_adv_d;
    logic [4:0]       val_d;
    logic             ovr_d;

    // Search the enable mask starting at base (incl=1) or just after base
    // (incl=0), wrapping modulo 4. Falls back to base when nothing else is
    // enabled, so a lone enabled source re-selects itself.
    function automatic logic [1:0] find_enabled(input logic [1:0] base,
                                                input logic [3:0] en,
                                                input logic       incl);
        logic [1:0] res;
        logic [1:0] cand;
        res = base;
        // Walk from the farthest offset down so the nearest match wins.
        for (int k = 3; k >= 0; k--) begin
            cand = base + 2'(k);
            if (en[cand] && ((k != 0) || incl)) begin
                res = cand;
            end
        end
        return res;
    endfunction

    assign src_arr[0] = src0;
    assign src_arr[1] = src1;
    assign src_arr[2] = src2;
    assign src_arr[3] = src3;

    // Advance decision, next-index search and clamping of the shown source.
    always_comb begin
        cur_src     = src_arr[sel_q];
        step_edge   = step & ~step_q;
        dwell_done  = mode_auto && (cnt_q == DWELL_LAST);
        cur_off     = ~src_en[sel_q];
        advance     = dwell_done | step_edge | cur_off;
        sel_first_d = find_enabled(sel_q, src_en, 1'b1);
        sel_adv_d   = find_enabled(sel_q, src_en, 1'b0);
        ovr_d       = (cur_src > 5'd19);
        val_d       = ovr_d ? 5'd19 : cur_src;
    end

    // Sequencer FSM with registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            val_q   <= 5'd0;
            ovr_q   <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            step_q <= step;
            if (src_en == 4'b0000) begin
                // Nothing to show: park blank; frz has no effect here.
                state_q <= ST_BLANK;
                cnt_q   <= '0;
                val_q   <= 5'd0;
                ovr_q   <= 1'b0;
                blank_q <= 1'b1;
            end else if (state_q == ST_BLANK) begin
                // Leaving blank: take the first enabled source at or after
                // the last index; digits follow one cycle later.
                state_q <= ST_SHOW;
                sel_q   <= sel_first_d;
                cnt_q   <= '0;
                blank_q <= 1'b0;
            end else begin
                blank_q <= 1'b0;
                if (advance) begin
                    sel_q <= sel_adv_d;
                    cnt_q <= '0;
                end else if (mode_auto) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                end
                // Freeze holds the digits while the index keeps moving.
                if (!frz) begin
                    val_q <= val_d;
                    ovr_q <= ovr_d;
                end
            end
        end
    end

    assign disp_val   = val_q;
    assign disp_sel   = sel_q;
    assign disp_blank = blank_q;
    assign ovr        = ovr_q;

endmodule
